uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter that consumes the CPU data-store bus (wr_req/wr_sel/wr_addr/wr_data, rd_req/rd_addr) alongside the data RAM. CPU stores to TXDATA enqueue bytes into an internal FIFO. A bit-serial FSM drains the FIFO onto uart_txd (8N1, LSB first). Status and baud registers are readable so firmware can poll.

Parameters:
BASE_ADDR, 32'h1000_0000, base of the 16-byte register window; addr[31:4] must match BASE_ADDR[31:4].
FIFO_DEPTH, 8, TX FIFO entries; power of two, >=2.
CLKS_PER_BIT, 434, reset value of the BAUD register (50 MHz / 115200).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
wr_req  input  1  CPU store request.
wr_sel  input  4  byte-lane enables of the store.
wr_addr  input  32  store address.
wr_data  input  32  store data.
rd_req  input  1  CPU load request.
rd_addr  input  32  load address.
rd_data  output  32  load data; combinational.
uart_txd  output  1  serial output, registered; idle high.
busy  output  1  high while the FSM is not in IDLE or the FIFO is non-empty.

Behaviour:
- Register map (byte offsets, word access):
  - 0x0 TXDATA: write-only; reads return 0.
  - 0x4 STATUS: read-only except the W1C bit. [0] full, [1] empty, [2] fsm_active, [3] overflow (sticky), [11:8] fifo count.
  - 0x8 BAUD: [15:0] read/write; reset value CLKS_PER_BIT.
  - 0xC: reserved; reads 0, writes ignored.
- Write hit: wr_req & addr match & offset. Enqueue requires wr_sel[0]; data is wr_data[7:0]. Writes with wr_sel[0]=0 to TXDATA are ignored.
- STATUS write with wr_data[3]=1 and wr_sel[0] clears overflow.
- BAUD write needs wr_sel[1:0]=2'b11. Written values below 2 are stored as 2.
- rd_data = selected register when rd_req & window hit; otherwise 32'h0. No side effects on read.
- FIFO:
  - Enqueue at a clock edge when the write hits and the FIFO is not full, using the pre-edge count.
  - A write while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when non-full and non-empty leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_txd=1. If the FIFO is non-empty, pop into the shift register, latch BAUD into bit_len, and go to START.
  - Each of START, DATA, STOP lasts bit_len cycles; a down-counter reloads at every bit boundary.
  - START: txd=0. DATA: 8 bits LSB first, bit index 0..7. STOP: txd=1, one bit.
  - After STOP: go to IDLE, or chain directly to START if the FIFO is non-empty (pop on the same edge, no idle gap).
- Latency: a TXDATA write at edge N with IDLE and an empty FIFO gives the pop at edge N+1 and txd low from edge N+2. Frame length is 10*bit_len cycles.
- A BAUD write mid-frame takes effect at the next frame start only.
- Reset (any time, including mid-frame) at the edge it is sampled:
  - uart_txd=1, FSM=IDLE, FIFO emptied, overflow=0, BAUD=CLKS_PER_BIT, counters=0.
  - busy=0, rd_data follows the reset register values.

Optional Feature:
UART_TX_PARITY_EN:
- Defined: adds state PARITY between DATA and STOP, transmitting the even-parity bit (XOR of the 8 data bits) for bit_len cycles. Frame is 11*bit_len. STATUS[4] reads 1.
- Undefined: no PARITY state, 8N1 only, STATUS[4] reads 0.

Decomposition:
- Shared header uart_tx_defines.vh: register offsets, STATUS bit positions, FSM state encodings (2-bit; 3-bit with parity), minimum-baud constant 2.
- One sub-module: uart_tx_fifo, a synchronous FIFO with push, pop, full, empty, and count outputs, parameterised by depth and width=8.

Test Plan:
1. CLKS_PER_BIT=4; store 0x55 to TXDATA with wr_sel=4'b0001 -> txd low at N+2 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high for 4; frame lasts 40 cycles; busy falls after STOP.
2. Nine back-to-back stores (0x01..0x09) while a frame is active -> 8 accepted (count=8, full=1), 0x09 dropped, STATUS=0x0000_080D. Writing STATUS bit3=1 clears overflow. Bytes emit in order with no idle gap between frames.
3. Store with wr_sel=4'b0010 to TXDATA -> no enqueue, empty stays 1, txd stays high.
4. Write BAUD=1 -> reads back 2. Write BAUD=8 mid-frame -> current frame keeps the old bit_len; the next frame's start bit lasts 8 cycles.
5. Assert rst during DATA bit 3 -> next cycle txd=1, STATUS=0x0000_0002, BAUD=CLKS_PER_BIT; the queued bytes are never sent.
6. With UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 before stop; frame=44 cycles at bit_len=4; STATUS[4]=1.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register word offsets,
// STATUS bit positions, FSM encodings and baud clamp. Optional macro: UART_TX_PARITY_EN.
package uart_tx_mmio_pkg;

  // Word offsets within the 16-byte window, compared against addr[3:2].
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_ACTIVE  = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_PARITY  = 4;
  localparam int ST_CNT_LSB = 8;

  localparam logic [15:0] MIN_BAUD = 16'd2;

`ifdef UART_TX_PARITY_EN
  localparam int         STATE_W   = 3;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic       PARITY_EN = 1'b1;
`else
  localparam int         STATE_W   = 2;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_DATA    = 2'd2;
  localparam logic [1:0] S_STOP    = 2'd3;
  localparam logic       PARITY_EN = 1'b0;
`endif

  // A bit time shorter than two cycles cannot be produced, so small values saturate.
  function automatic logic [15:0] clamp_baud(input logic [15:0] value);
    return (value < MIN_BAUD) ? MIN_BAUD : value;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the UART transmitter; depth must be a power of two.
module uart_tx_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO, STATUS and BAUD registers.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] CLKS_PER_BIT = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [3:0]  wr_sel,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        uart_txd,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic               wr_hit;
  logic               rd_hit;
  logic               tx_store;
  logic               ovf_clear;
  logic               baud_store;
  logic               overflow;
  logic [15:0]        baud;
  logic               pop;
  logic [7:0]         fifo_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [STATE_W-1:0] state;
  logic [15:0]        cnt;
  logic [15:0]        bit_len;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               parity_q;
  logic               txd_q;
  logic               bit_done;
  logic [31:0]        status_word;
  logic               unused_bits;

  assign wr_hit     = wr_req && (wr_addr[31:4] == BASE_ADDR[31:4]);
  assign rd_hit     = rd_req && (rd_addr[31:4] == BASE_ADDR[31:4]);
  assign tx_store   = wr_hit && (wr_addr[3:2] == OFF_TXDATA) && wr_sel[0];
  assign ovf_clear  = wr_hit && (wr_addr[3:2] == OFF_STATUS) && wr_sel[0] && wr_data[ST_OVF];
  assign baud_store = wr_hit && (wr_addr[3:2] == OFF_BAUD) && (wr_sel[1:0] == 2'b11);
  assign bit_done   = (cnt == '0);
  assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_sel[3:2], wr_data[31:16]};

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_store),
    .push_data (wr_data[7:0]),
    .pop       (pop),
    .pop_data  (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A store that finds the FIFO full is lost even if a pop frees a slot on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      baud     <= CLKS_PER_BIT;
    end else begin
      if (tx_store && fifo_full) overflow <= 1'b1;
      else if (ovf_clear)        overflow <= 1'b0;
      if (baud_store) baud <= clamp_baud(wr_data[15:0]);
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    pop = 1'b0;
    if (!fifo_empty && (state == S_IDLE || (state == S_STOP && bit_done))) pop = 1'b1;
  end

  // Each bit lasts bit_len cycles; cnt counts down and reloads at every boundary.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_len  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      parity_q <= 1'b0;
    end else if (pop) begin
      state    <= S_START;
      shreg    <= fifo_q;
      parity_q <= ^fifo_q;
      bit_len  <= baud;
      cnt      <= baud - 16'd1;
    end else if (state != S_IDLE) begin
      if (!bit_done) begin
        cnt <= cnt - 16'd1;
      end else begin
        cnt <= bit_len - 16'd1;
        case (state)
          S_START: begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
          S_DATA: begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
            if (bit_idx == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            state <= S_STOP;
`else
            if (bit_idx == 3'd7) state <= S_STOP;
`endif
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // The line register trails the FSM by one cycle, giving the two-edge start latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd_q <= 1'b1;
    end else begin
      case (state)
        S_START: txd_q <= 1'b0;
        S_DATA:  txd_q <= shreg[0];
`ifdef UART_TX_PARITY_EN
        S_PARITY: txd_q <= parity_q;
`endif
        default: txd_q <= 1'b1;
      endcase
    end
  end

  assign uart_txd = txd_q;
  assign busy     = (state != S_IDLE) || !fifo_empty;

  always_comb begin
    status_word                       = '0;
    status_word[ST_FULL]              = fifo_full;
    status_word[ST_EMPTY]             = fifo_empty;
    status_word[ST_ACTIVE]            = (state != S_IDLE);
    status_word[ST_OVF]               = overflow;
    status_word[ST_PARITY]            = PARITY_EN;
    status_word[ST_CNT_LSB+3:ST_CNT_LSB] = 4'(fifo_count);
  end

  always_comb begin
    rd_data = '0;
    if (rd_hit) begin
      case (rd_addr[3:2])
        OFF_STATUS: rd_data = status_word;
        OFF_BAUD:   rd_data = {16'h0, baud};
        default:    rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: compares the captured serial line against a
// frame-level model (bit lists per byte) under directed and randomized stores.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_TX   = BASE;
  localparam logic [31:0] A_ST   = BASE + 32'h4;
  localparam logic [31:0] A_BAUD = BASE + 32'h8;
  localparam logic [31:0] A_RSVD = BASE + 32'hC;
  localparam int          BL0    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif
  localparam int          NBITS  = 10 + PBIT;
  localparam logic [31:0] ST_PAR = (PBIT != 0) ? 32'h10 : 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_req = 1'b0;
  logic [3:0]  wr_sel = '0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] rd_data;
  logic        uart_txd;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit cap_txd[$];
  bit cap_busy[$];
  bit exp_q[$];

  uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .CLKS_PER_BIT(16'(BL0))) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .uart_txd (uart_txd),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    wr_req = 1'b1; wr_addr = a; wr_sel = s; wr_data = d;
    @(posedge clk); #1;
    wr_req = 1'b0; wr_addr = '0; wr_sel = '0; wr_data = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rd_req = 1'b1; rd_addr = a;
    #1;
    d = rd_data;
    rd_req = 1'b0; rd_addr = '0;
  endtask

  task automatic capture(input int n);
    cap_txd.delete();
    cap_busy.delete();
    repeat (n) begin
      @(posedge clk); #1;
      cap_txd.push_back(uart_txd);
      cap_busy.push_back(busy);
    end
  endtask

  // Line model: one idle cycle after the store edge, then whole frames, then idle forever.
  function automatic void exp_reset();
    exp_q.delete();
    exp_q.push_back(1'b1);
  endfunction

  function automatic void exp_frame(input logic [7:0] b, input int bl);
    int ones = 0;
    repeat (bl) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      ones += int'(b[i]);
      repeat (bl) exp_q.push_back(b[i]);
    end
    if (PBIT != 0) repeat (bl) exp_q.push_back((ones % 2) == 1);
    repeat (bl) exp_q.push_back(1'b1);
  endfunction

  function automatic bit exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 1'b1;
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < cap_txd.size(); i++)
      if (cap_txd[i] !== exp_at(i)) return i;
    return -1;
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %0b want 1", uart_txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    bus_read(A_ST, v);
    total++; if (v !== (32'h2 | ST_PAR)) begin bad++; $display("FAIL reset_status: got %h want %h", v, 32'h2 | ST_PAR); end
    bus_read(A_BAUD, v);
    total++; if (v !== 32'(BL0)) begin bad++; $display("FAIL reset_baud: got %h want %h", v, BL0); end
    rst = 1'b0;
    @(posedge clk); #1;
    bus_read(A_TX, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL txdata_read: got %h want 0", v); end
    bus_read(A_RSVD, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL rsvd_read: got %h want 0", v); end
    bus_read(BASE + 32'h18, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL miss_read: got %h want 0", v); end
    rd_addr = A_BAUD; #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL noreq_read: got %h want 0", rd_data); end
    rd_addr = '0;
  endtask

  task automatic test_single_frame(input logic [7:0] b, input string name);
    int d;
    int fl = NBITS * BL0;
    logic [31:0] v;
    bus_write(A_TX, 4'b0001, {24'h0, b});
    bus_read(A_ST, v);
    total++; if (v[31:8] !== 24'h1 || v[1] !== 1'b0) begin bad++; $display("FAIL %s_queued: status %h want count 1, not empty", name, v); end
    capture(fl + 8);
    exp_reset();
    exp_frame(b, BL0);
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL %s_wave: cycle %0d txd=%0b want %0b", name, d, cap_txd[d], exp_at(d)); end
    total++; if (cap_busy[fl-1] !== 1'b1) begin bad++; $display("FAIL %s_busy_stop: got %0b want 1", name, cap_busy[fl-1]); end
    total++; if (cap_busy[fl] !== 1'b0) begin bad++; $display("FAIL %s_busy_idle: got %0b want 0", name, cap_busy[fl]); end
  endtask

  task automatic test_parity_flag();
    logic [31:0] v;
    bus_read(A_ST, v);
    total++; if (v[4] !== 1'(PBIT)) begin bad++; $display("FAIL parity_flag: got %0b want %0d", v[4], PBIT); end
    test_single_frame(8'h07, "parity");
  endtask

  task automatic test_back_to_back();
    int d;
    logic [31:0] st;
    bus_write(A_TX, 4'b0001, 32'hA5);
    exp_reset();
    exp_frame(8'hA5, BL0);
    for (int i = 1; i <= 8; i++) exp_frame(8'(i), BL0);
    fork
      capture(9 * NBITS * BL0 + 8);
      begin
        for (int i = 1; i <= 9; i++) bus_write(A_TX, 4'b0001, 32'(i));
        bus_read(A_ST, st);
        total++; if (st !== (32'h080D | ST_PAR)) begin bad++; $display("FAIL b2b_full_status: got %h want %h", st, 32'h080D | ST_PAR); end
        bus_write(A_ST, 4'b0001, 32'h8);
        bus_read(A_ST, st);
        total++; if (st !== (32'h0805 | ST_PAR)) begin bad++; $display("FAIL b2b_ovf_clear: got %h want %h", st, 32'h0805 | ST_PAR); end
      end
    join
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL b2b_wave: cycle %0d txd=%0b want %0b", d, cap_txd[d], exp_at(d)); end
  endtask

  task automatic test_sel_ignore();
    int d;
    logic [31:0] v;
    bus_write(A_TX, 4'b0010, 32'hFF);
    bus_write(A_TX, 4'b1110, 32'h3C);
    bus_write(BASE + 32'h10, 4'b1111, 32'h11);
    bus_write(A_RSVD, 4'b1111, 32'hFFFF_FFFF);
    bus_read(A_ST, v);
    total++; if (v !== (32'h2 | ST_PAR)) begin bad++; $display("FAIL sel_status: got %h want %h", v, 32'h2 | ST_PAR); end
    capture(20);
    exp_reset();
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL sel_idle_wave: cycle %0d txd=%0b want 1", d, cap_txd[d]); end
  endtask

  task automatic test_baud();
    int d;
    logic [31:0] v;
    logic [7:0] x = 8'($urandom);
    logic [7:0] y = 8'($urandom);
    bus_write(A_BAUD, 4'b0011, 32'($urandom_range(0, 1)));
    bus_read(A_BAUD, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL baud_clamp: got %h want 2", v); end
    bus_write(A_BAUD, 4'b0001, 32'h30);
    bus_write(32'h2000_0008, 4'b0011, 32'h30);
    bus_read(A_BAUD, v);
    total++; if (v !== 32'h2) begin bad++; $display("FAIL baud_ignored: got %h want 2", v); end
    bus_write(A_BAUD, 4'b0011, 32'hABCD_0004);
    bus_read(A_BAUD, v);
    total++; if (v !== 32'h4) begin bad++; $display("FAIL baud_write: got %h want 4", v); end
    bus_write(A_TX, 4'b0001, {24'h0, x});
    exp_reset();
    exp_frame(x, 4);
    exp_frame(y, 8);
    fork
      capture(NBITS * 12 + 8);
      begin
        repeat (10) @(posedge clk);
        #1;
        bus_write(A_BAUD, 4'b0011, 32'h8);
        bus_write(A_TX, 4'b0001, {24'h0, y});
      end
    join
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL baud_mid_frame_wave: cycle %0d txd=%0b want %0b", d, cap_txd[d], exp_at(d)); end
    bus_write(A_BAUD, 4'b0011, 32'(BL0));
  endtask

  task automatic test_reset_mid_frame();
    int d;
    logic [31:0] v;
    logic [7:0] b0 = 8'($urandom);
    bus_write(A_TX, 4'b0001, {24'h0, b0});
    bus_write(A_TX, 4'b0001, 32'($urandom));
    bus_write(A_TX, 4'b0001, 32'($urandom));
    bus_write(A_BAUD, 4'b0011, 32'h6);
    repeat (14) @(posedge clk);
    #1;
    total++; if (uart_txd !== b0[2]) begin bad++; $display("FAIL mid_bit2: got %0b want %0b", uart_txd, b0[2]); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL midrst_txd: got %0b want 1", uart_txd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %0b want 0", busy); end
    bus_read(A_ST, v);
    total++; if (v !== (32'h2 | ST_PAR)) begin bad++; $display("FAIL midrst_status: got %h want %h", v, 32'h2 | ST_PAR); end
    bus_read(A_BAUD, v);
    total++; if (v !== 32'(BL0)) begin bad++; $display("FAIL midrst_baud: got %h want %h", v, BL0); end
    capture(60);
    exp_reset();
    d = first_diff();
    total++; if (d >= 0) begin bad++; $display("FAIL midrst_quiet: cycle %0d txd=%0b want 1", d, cap_txd[d]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      int bl = $urandom_range(2, 5);
      int k  = $urandom_range(2, 5);
      int nacc = 0;
      int d;
      logic [7:0] bytes [5];
      logic [3:0] sels [5];
      for (int i = 0; i < k; i++) begin
        bytes[i] = 8'($urandom);
        sels[i]  = 4'($urandom);
        if (i == 0) sels[i][0] = 1'b1;
      end
      bus_write(A_BAUD, 4'b0011, 32'(bl));
      exp_reset();
      for (int i = 0; i < k; i++)
        if (sels[i][0]) begin
          exp_frame(bytes[i], bl);
          nacc++;
        end
      bus_write(A_TX, sels[0], {24'h0, bytes[0]});
      fork
        capture(nacc * NBITS * bl + 8);
        for (int i = 1; i < k; i++) bus_write(A_TX, sels[i], {24'h0, bytes[i]});
      join
      d = first_diff();
      total++; if (d >= 0) begin bad++; $display("FAIL rand%0d_wave: bl=%0d cycle %0d txd=%0b want %0b", it, bl, d, cap_txd[d], exp_at(d)); end
    end
    bus_write(A_BAUD, 4'b0011, 32'(BL0));
  endtask

  initial begin
    test_reset();
    test_single_frame(8'h55, "single");
    test_parity_flag();
    test_back_to_back();
    test_sel_ignore();
    test_baud();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
